// File: rtl/seq_mult_alu.sv
// Sequential shift-add multiplier with start/busy/done handshake and seven-segment readout.
// Optional two's-complement operands when SEQ_MULT_SIGNED_EN is defined.
module seq_mult_alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product,
  output logic [7*(WIDTH/4)-1:0] hex_a,
  output logic [7*(WIDTH/4)-1:0] hex_b,
  output logic [7*(WIDTH/2)-1:0] hex_p
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned NA = WIDTH / 4;
  localparam int unsigned NP = WIDTH / 2;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  if (WIDTH < 4 || WIDTH > 16 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("seq_mult_alu: WIDTH must be a multiple of 4 in 4..16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] cap_a, cap_b, mcand;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [PW-1:0]    result_c;

`ifdef SEQ_MULT_SIGNED_EN
  logic neg;
  // Magnitudes fit WIDTH bits unsigned, including the most-negative value
  assign mag_a_c  = a[WIDTH-1] ? WIDTH'(0) - a : a;
  assign mag_b_c  = b[WIDTH-1] ? WIDTH'(0) - b : b;
  assign result_c = neg ? PW'(0) - acc : acc;
`else
  assign mag_a_c  = a;
  assign mag_b_c  = b;
  assign result_c = acc;
`endif

  // Conditional add of the multiplicand into the upper half, carry kept
  assign sum_c = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : (WIDTH+1)'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      cap_a   <= '0;
      cap_b   <= '0;
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cap_a <= a;
            cap_b <= b;
            mcand <= mag_a_c;
            acc   <= {WIDTH'(0), mag_b_c};
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
            neg   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
            state <= RUN;
          end
        end
        RUN: begin
          acc <= {sum_c, acc[WIDTH-1:1]};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          product <= result_c;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Digits decode only registered values
  for (genvar k = 0; k < NA; k++) begin : g_hex_ab
    assign hex_a[7*k +: 7] = seg7(cap_a[4*k +: 4]);
    assign hex_b[7*k +: 7] = seg7(cap_b[4*k +: 4]);
  end

  for (genvar k = 0; k < NP; k++) begin : g_hex_p
    assign hex_p[7*k +: 7] = seg7(product[4*k +: 4]);
  end

endmodule

// File: tb/tb_seq_mult_alu.sv
// Self-checking bench for seq_mult_alu: table-driven WIDTH=4 vectors plus
// hand-written sequences for ignored restart, mid-op reset and WIDTH=8 back-to-back.
module tb_seq_mult_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  p4;
  logic [6:0]  ha4, hb4;
  logic [13:0] hp4;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;
  logic [13:0] ha8, hb8;
  logic [27:0] hp8;

  seq_mult_alu #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(p4),
    .hex_a(ha4), .hex_b(hb4), .hex_p(hp4)
  );

  seq_mult_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(p8),
    .hex_a(ha8), .hex_b(hb8), .hex_p(hp8)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  localparam logic [6:0] S0 = 7'b1000000;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] tab [16];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tab[n];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full WIDTH=4 operation; operands are scrambled after capture
  task automatic mul4(input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] exp, input logic [7:0] prev);
    int lat;
    int bcnt;
    lat = 0;
    bcnt = 0;
    @(negedge clk);
    a4 = a; b4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; a4 = ~a; b4 = ~b;
    lat = 1;
    if (busy4) bcnt++;
    check("product_hold", 32'(p4), 32'(prev));
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy4) bcnt++;
    end
    check("latency", 32'(lat), 32'd6);
    check("busy_cycles", 32'(bcnt), 32'd5);
    check("product", 32'(p4), 32'(exp));
    check("hex_p", 32'(hp4), 32'({seg(exp[7:4]), seg(exp[3:0])}));
    check("hex_a", 32'(ha4), 32'(seg(a)));
    check("hex_b", 32'(hb4), 32'(seg(b)));
    @(negedge clk);
    check("done_pulse_width", 32'(done4), 32'd0);
  endtask

  initial begin
    vec_t vecs [8];
    logic [7:0]  last;
    logic [15:0] exp8;
    int dn, first, second;

`ifdef SEQ_MULT_SIGNED_EN
    vecs = '{'{4'hD, 4'h5, 8'hF1}, '{4'h8, 4'h8, 8'h40}, '{4'h0, 4'h9, 8'h00},
             '{4'h3, 4'h5, 8'h0F}, '{4'hF, 4'hF, 8'h01}, '{4'h7, 4'h8, 8'hC8},
             '{4'h2, 4'hE, 8'hFC}, '{4'h8, 4'h1, 8'hF8}};
    exp8 = 16'h0001;
`else
    vecs = '{'{4'hF, 4'hF, 8'hE1}, '{4'h0, 4'h9, 8'h00}, '{4'h3, 4'h5, 8'h0F},
             '{4'h1, 4'h1, 8'h01}, '{4'h8, 4'h2, 8'h10}, '{4'h7, 4'h9, 8'h3F},
             '{4'hF, 4'h0, 8'h00}, '{4'hC, 4'hD, 8'h9C}};
    exp8 = 16'hFE01;
`endif

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_product", 32'(p4), 32'd0);
    check("rst_hex_a", 32'(ha4), 32'(S0));
    check("rst_hex_b", 32'(hb4), 32'(S0));
    check("rst_hex_p", 32'(hp4), 32'({S0, S0}));
    check("rst_hex_p8", hp8[27:0], 32'({S0, S0, S0, S0}));
    rst_n = 1'b1;

    last = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mul4(vecs[i].a, vecs[i].b, vecs[i].p, last);
      last = vecs[i].p;
    end

    // Restart while busy is ignored
    @(negedge clk);
    a4 = 4'h2; b4 = 4'h3; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done4) dn++;
    end
    check("ignored_start_dones", 32'(dn), 32'd1);
    check("ignored_start_product", 32'(p4), 32'h06);
    check("ignored_start_hex_a", 32'(ha4), 32'(seg(4'h2)));

    // Reset in the middle of an operation
    @(negedge clk);
    a4 = 4'h5; b4 = 4'h5; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy4), 32'd0);
    check("midrst_done", 32'(done4), 32'd0);
    check("midrst_product", 32'(p4), 32'd0);
    check("midrst_hex_a", 32'(ha4), 32'(S0));
    check("midrst_hex_p", 32'(hp4), 32'({S0, S0}));
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done4 || busy4) dn++;
    end
    check("midrst_no_activity", 32'(dn), 32'd0);
    mul4(4'h3, 4'h5, 8'h0F, 8'h00);

    // WIDTH=8 with start held high: back-to-back operations
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    dn = 0; first = 0; second = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done8) begin
        dn++;
        if (dn == 1) begin
          first = i;
          check("w8_first_product", 32'(p8), 32'(exp8));
        end
        if (dn == 2) second = i;
      end
    end
    start8 = 1'b0;
    check("w8_done_count", 32'(dn), 32'd2);
    check("w8_first_cycle", 32'(first), 32'd10);
    check("w8_second_cycle", 32'(second), 32'd20);
    check("w8_product", 32'(p8), 32'(exp8));
    check("w8_hex_p", hp8[27:0],
          32'({seg(exp8[15:12]), seg(exp8[11:8]), seg(exp8[7:4]), seg(exp8[3:0])}));
    check("w8_hex_a", 32'(ha8), 32'({seg(4'hF), seg(4'hF)}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
